// File: rtl/mission_elapsed_timer.sv
// Mission elapsed timer.
// Edge-detects the 1 kHz divider output on the 1 MHz system clock and keeps
// a ms/sec/min/hour count. It emits 1 ms, 1 Hz and sample strobes, and offers
// a coherent four-phase snapshot of the time to the telemetry packetizer.
module mission_elapsed_timer #(
  parameter int MS_PER_SEC  = 1000,
  parameter int SEC_PER_MIN = 60,
  parameter int SAMPLE_DIV  = 100
) (
  input  logic       CLK_1MHZ_IN,
  input  logic       RESET,
  input  logic       CLK_1KHZ_IN,
  input  logic       CLEAR,
  input  logic       SNAP_REQ,
  output logic       SNAP_ACK,
  output logic [9:0] SNAP_MS,
  output logic [5:0] SNAP_SEC,
  output logic [5:0] SNAP_MIN,
  output logic [7:0] SNAP_HOUR,
  output logic       TICK_1MS,
  output logic       PPS_OUT,
  output logic       SAMPLE_STROBE,
  output logic       OVF
);

  localparam logic [9:0] MS_LAST   = 10'(MS_PER_SEC - 1);
  localparam logic [5:0] SEC_LAST  = 6'(SEC_PER_MIN - 1);
  localparam logic [9:0] SAMP_LAST = 10'(SAMPLE_DIV - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } snapState_e;

  logic       prevKhz_q;
  logic [9:0] ms_q, ms_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic [9:0] samp_q, samp_d;
  logic       ovf_q, ovf_d;
  logic       tick_q, tick_d;
  logic       pps_q, pps_d;
  logic       sample_q, sample_d;
  logic       tickDet;

  snapState_e state_q;
  logic       ack_q;
  logic [9:0] snapMs_q;
  logic [5:0] snapSec_q;
  logic [5:0] snapMin_q;
  logic [7:0] snapHour_q;

  // Next-state of the count chain: CLEAR wins over a tick, all carries ripple in one cycle.
  always_comb begin
    tickDet  = CLK_1KHZ_IN & ~prevKhz_q;
    ms_d     = ms_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    samp_d   = samp_q;
    ovf_d    = ovf_q;
    tick_d   = 1'b0;
    pps_d    = 1'b0;
    sample_d = 1'b0;
    if (CLEAR) begin
      ms_d   = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
      samp_d = '0;
      ovf_d  = 1'b0;
    end else if (tickDet) begin
      tick_d = 1'b1;
      if (samp_q == SAMP_LAST) begin
        samp_d   = '0;
        sample_d = 1'b1;
      end else begin
        samp_d = samp_q + 10'd1;
      end
      if (ms_q == MS_LAST) begin
        ms_d  = '0;
        pps_d = 1'b1;
        if (sec_q == SEC_LAST) begin
          sec_d = '0;
          if (min_q == SEC_LAST) begin
            min_d = '0;
            if (hour_q == 8'd255) begin
              hour_d = '0;
              ovf_d  = 1'b1;
            end else begin
              hour_d = hour_q + 8'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        ms_d = ms_q + 10'd1;
      end
    end
  end

  // Count registers, strobes and edge history; history resets high so the divider's reset-high output gives no false tick.
  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      prevKhz_q <= 1'b1;
      ms_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      samp_q    <= '0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
      pps_q     <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      prevKhz_q <= CLK_1KHZ_IN;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      samp_q    <= samp_d;
      ovf_q     <= ovf_d;
      tick_q    <= tick_d;
      pps_q     <= pps_d;
      sample_q  <= sample_d;
    end
  end

  // Snapshot handshake: capture the registered (pre-tick) time once per REQ level, hold until REQ drops.
  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      snapMs_q   <= '0;
      snapSec_q  <= '0;
      snapMin_q  <= '0;
      snapHour_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (SNAP_REQ) begin
            snapMs_q   <= ms_q;
            snapSec_q  <= sec_q;
            snapMin_q  <= min_q;
            snapHour_q <= hour_q;
            ack_q      <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (!SNAP_REQ) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SNAP_ACK      = ack_q;
  assign SNAP_MS       = snapMs_q;
  assign SNAP_SEC      = snapSec_q;
  assign SNAP_MIN      = snapMin_q;
  assign SNAP_HOUR     = snapHour_q;
  assign TICK_1MS      = tick_q;
  assign PPS_OUT       = pps_q;
  assign SAMPLE_STROBE = sample_q;
  assign OVF           = ovf_q;

endmodule

// File: tb/tb_mission_elapsed_timer.sv
// Testbench for mission_elapsed_timer.
// Uses reduced rollover parameters so a full hour wrap fits in a short run.
// A behavioural model tracks total elapsed ms as one integer and derives the fields arithmetically.
module tb_mission_elapsed_timer;

  localparam int MS   = 5;
  localparam int SPM  = 3;
  localparam int DIV  = 7;
  localparam int HOUR = MS * SPM * SPM;
  localparam int FULL = HOUR * 256;

  logic       clk = 1'b0;
  logic       rstN;
  logic       khz;
  logic       clr;
  logic       req;
  logic       snapAck;
  logic [9:0] snapMs;
  logic [5:0] snapSec;
  logic [5:0] snapMin;
  logic [7:0] snapHour;
  logic       tick1ms;
  logic       pps;
  logic       sampleStrobe;
  logic       ovf;

  int checks = 0;
  int passes = 0;

  // Behavioural reference state
  longint mTotal;
  int     mSince;
  bit     mOvf, mPrev, mHold, mTick, mPps, mSample;
  int     mSnapMs, mSnapSec, mSnapMin, mSnapHour;

  typedef struct packed {
    logic       khz;
    logic       clr;
    logic       req;
    logic       expTick;
    logic       expPps;
    logic       expAck;
    logic [9:0] expSnapMs;
    logic [5:0] expSnapSec;
  } vecT;

  vecT vecs [24];

  mission_elapsed_timer #(
    .MS_PER_SEC (MS),
    .SEC_PER_MIN(SPM),
    .SAMPLE_DIV (DIV)
  ) dut (
    .CLK_1MHZ_IN  (clk),
    .RESET        (rstN),
    .CLK_1KHZ_IN  (khz),
    .CLEAR        (clr),
    .SNAP_REQ     (req),
    .SNAP_ACK     (snapAck),
    .SNAP_MS      (snapMs),
    .SNAP_SEC     (snapSec),
    .SNAP_MIN     (snapMin),
    .SNAP_HOUR    (snapHour),
    .TICK_1MS     (tick1ms),
    .PPS_OUT      (pps),
    .SAMPLE_STROBE(sampleStrobe),
    .OVF          (ovf)
  );

  // 1 MHz system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    mTotal = 0; mSince = 0; mOvf = 0; mPrev = 1; mHold = 0;
    mTick = 0; mPps = 0; mSample = 0;
    mSnapMs = 0; mSnapSec = 0; mSnapMin = 0; mSnapHour = 0;
  endtask

  task automatic modelEdge();
    bit tickNow;
    tickNow = khz && !mPrev;
    mPrev   = khz;
    if (!mHold && req) begin
      mSnapMs   = int'(mTotal % MS);
      mSnapSec  = int'((mTotal / MS) % SPM);
      mSnapMin  = int'((mTotal / (MS * SPM)) % SPM);
      mSnapHour = int'((mTotal / HOUR) % 256);
      mHold     = 1;
    end else if (mHold && !req) begin
      mHold = 0;
    end
    mTick = 0; mPps = 0; mSample = 0;
    if (clr) begin
      mTotal = 0; mSince = 0; mOvf = 0;
    end else if (tickNow) begin
      mTotal++;
      mSince++;
      mTick   = 1;
      mPps    = (mTotal % MS) == 0;
      mSample = (mSince % DIV) == 0;
      if ((mTotal % FULL) == 0) mOvf = 1;
    end
  endtask

  task automatic compareModel();
    checkOutput("tick", int'(tick1ms), int'(mTick));
    checkOutput("pps", int'(pps), int'(mPps));
    checkOutput("sample", int'(sampleStrobe), int'(mSample));
    checkOutput("ack", int'(snapAck), int'(mHold));
    checkOutput("ovf", int'(ovf), int'(mOvf));
    checkOutput("snapMs", int'(snapMs), mSnapMs);
    checkOutput("snapSec", int'(snapSec), mSnapSec);
    checkOutput("snapMin", int'(snapMin), mSnapMin);
    checkOutput("snapHour", int'(snapHour), mSnapHour);
  endtask

  task automatic applyStimulus(input logic k, input logic c, input logic r);
    khz = k; clr = c; req = r;
    @(posedge clk);
    modelEdge();
    #1;
    compareModel();
  endtask

  task automatic applyReset(input logic k);
    rstN = 1'b0; khz = k; clr = 1'b0; req = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic doSnapshot();
    applyStimulus(khz, 1'b0, 1'b1);
    checkOutput("snapAckRaised", int'(snapAck), 1);
    applyStimulus(khz, 1'b0, 1'b0);
    checkOutput("snapAckDropped", int'(snapAck), 0);
  endtask

  task automatic checkSnap(input string name, input int h, input int m, input int s, input int ms);
    checkOutput({name, "Hour"}, int'(snapHour), h);
    checkOutput({name, "Min"}, int'(snapMin), m);
    checkOutput({name, "Sec"}, int'(snapSec), s);
    checkOutput({name, "Ms"}, int'(snapMs), ms);
  endtask

  initial begin
    // Directed vectors: khz, clr, req, tick, pps, ack, snapMs, snapSec
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 6'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 6'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 6'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 6'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 6'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 6'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 6'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd1, 6'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 6'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 6'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 6'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd2, 6'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 6'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2, 6'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 6'd0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2, 6'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 6'd1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 6'd1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 6'd1};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 6'd1};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 6'd0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 6'd0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 6'd0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 6'd0};

    // Reset with the divider output high, then hold it high with no tick
    applyReset(1'b1);
    #1;
    checkOutput("resetAck", int'(snapAck), 0);
    checkOutput("resetOvf", int'(ovf), 0);
    checkOutput("resetTick", int'(tick1ms), 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("noTickWhileHigh", int'(tick1ms), 0);
    end

    // Table-driven directed sequence
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].khz, vecs[i].clr, vecs[i].req);
      checkOutput($sformatf("vec%0dTick", i), int'(tick1ms), int'(vecs[i].expTick));
      checkOutput($sformatf("vec%0dPps", i), int'(pps), int'(vecs[i].expPps));
      checkOutput($sformatf("vec%0dSample", i), int'(sampleStrobe), 0);
      checkOutput($sformatf("vec%0dAck", i), int'(snapAck), int'(vecs[i].expAck));
      checkOutput($sformatf("vec%0dSnapMs", i), int'(snapMs), int'(vecs[i].expSnapMs));
      checkOutput($sformatf("vec%0dSnapSec", i), int'(snapSec), int'(vecs[i].expSnapSec));
    end

    // One full hour, then run up to the last ms before the hour wrap, then wrap
    applyReset(1'b1);
    runTicks(HOUR);
    doSnapshot();
    checkSnap("oneHour", 1, 0, 0, 0);
    runTicks(FULL - 1 - HOUR);
    doSnapshot();
    checkSnap("preWrap", 255, SPM - 1, SPM - 1, MS - 1);
    checkOutput("preWrapOvf", int'(ovf), 0);
    runTicks(1);
    checkOutput("wrapPps", int'(pps), 1);
    doSnapshot();
    checkSnap("postWrap", 0, 0, 0, 0);
    checkOutput("postWrapOvf", int'(ovf), 1);

    // Randomized traffic against the model, OVF still set from the wrap
    for (int i = 0; i < 20000; i++) begin
      logic r;
      r = req;
      if ($urandom_range(0, 7) == 0) r = ~r;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 499) == 0), r);
    end

    // Async reset in the middle of a handshake
    applyStimulus(khz, 1'b0, 1'b1);
    applyStimulus(khz, 1'b0, 1'b1);
    checkOutput("ackBeforeReset", int'(snapAck), 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncAck", int'(snapAck), 0);
    checkOutput("asyncSnapMs", int'(snapMs), 0);
    checkOutput("asyncSnapHour", int'(snapHour), 0);
    checkOutput("asyncOvf", int'(ovf), 0);
    checkOutput("asyncTick", int'(tick1ms), 0);
    modelReset();
    req = 1'b0;
    khz = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    doSnapshot();
    checkSnap("afterReset", 0, 0, 0, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mission_elapsed_timer.md
Name: mission_elapsed_timer

Overview:
- Consumes the 1 kHz square wave from the 1 MHz→1 kHz clock divider.
- Maintains a mission elapsed time count: milliseconds, seconds, minutes, hours.
- Emits periodic strobes: a 1 Hz pulse and a sensor sample trigger.
- Gives the telemetry packetizer a coherent snapshot of the time through a four-phase req/ack handshake.
- Everything runs on the 1 MHz system clock; the 1 kHz input is treated as a synchronous data signal and edge-detected.

Parameters:
- MS_PER_SEC, 1000, millisecond ticks per second rollover.
- SEC_PER_MIN, 60, seconds per minute rollover; also used for minutes per hour.
- SAMPLE_DIV, 100, ms ticks between SAMPLE_STROBE pulses (legal range 1..1023).

Ports:
- CLK_1MHZ_IN  input  1  system clock; the only clock.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- CLK_1KHZ_IN  input  1  1 kHz square wave from the divider, same clock domain.
- CLEAR  input  1  synchronous clear of all counts and OVF, active-high.
- SNAP_REQ  input  1  snapshot request level (four-phase).
- SNAP_ACK  output  1  snapshot valid / acknowledge level.
- SNAP_MS  output  10  captured milliseconds, 0..MS_PER_SEC-1.
- SNAP_SEC  output  6  captured seconds, 0..59.
- SNAP_MIN  output  6  captured minutes, 0..59.
- SNAP_HOUR  output  8  captured hours, 0..255.
- TICK_1MS  output  1  one-cycle pulse per detected rising edge of CLK_1KHZ_IN.
- PPS_OUT  output  1  one-cycle pulse on each seconds increment.
- SAMPLE_STROBE  output  1  one-cycle pulse every SAMPLE_DIV ms.
- OVF  output  1  sticky flag, set on hour wrap 255→0.

Behaviour:
- Reset (RESET=0, async): all counters, snapshot registers, SNAP_ACK, TICK_1MS, PPS_OUT, SAMPLE_STROBE and OVF go to 0.
- Reset also sets the edge-detect history register to 1, matching the divider's reset-high output, so there is no spurious tick on release.
- Edge detect: prev <= CLK_1KHZ_IN each cycle. A tick occurs in the cycle where CLK_1KHZ_IN=1 and prev=0.
- TICK_1MS is registered: it goes high the cycle after the rising edge is sampled, for exactly 1 cycle.
- Count chain, on tick:
  - ms increments; at MS_PER_SEC-1, ms→0 and sec increments.
  - sec at 59 → 0, min increments.
  - min at 59 → 0, hour increments.
  - hour at 255 → 0 and OVF←1.
- All carries resolve in the same cycle. Counters are updated in the same cycle TICK_1MS is asserted.
- PPS_OUT asserts in the same cycle as the ms 999→0 update.
- Sample counter: increments on each tick. When it reaches SAMPLE_DIV-1 it resets to 0 and SAMPLE_STROBE pulses for 1 cycle, aligned with TICK_1MS.
  - The first strobe occurs on the SAMPLE_DIV-th tick after reset or CLEAR.
- CLEAR: the next edge zeroes ms, sec, min, hour, the sample counter and OVF; strobes are suppressed that cycle.
  - CLEAR has priority over a simultaneous tick; that tick is discarded.
  - CLEAR does not alter the snapshot registers or the handshake state.
- Snapshot FSM, states IDLE, HOLD:
  - IDLE, SNAP_REQ=1: capture the live ms/sec/min/hour into SNAP_*, set SNAP_ACK=1 on the next edge, go to HOLD.
  - HOLD: SNAP_* frozen and SNAP_ACK held at 1 while SNAP_REQ=1.
  - HOLD, SNAP_REQ=0: SNAP_ACK→0 on the next edge, return to IDLE.
  - A new capture requires SNAP_REQ to be seen low in IDLE first; holding REQ high captures only once.
- Tick and capture in the same cycle: the snapshot takes the pre-increment (currently registered) value. All four fields always come from the same cycle; no torn reads.
- Reset mid-handshake: SNAP_ACK drops immediately (async) and the FSM returns to IDLE.
- Widths: counters are unsigned with no saturation. Hour wraps modulo 256 and ms never exceeds MS_PER_SEC-1.

Test Plan:
- Reset release with CLK_1KHZ_IN=1, held high 10 cycles → no TICK_1MS. First 0→1 transition → TICK_1MS pulse 1 cycle later, ms=1.
- Real divider drive, 1000 ticks → exactly one PPS_OUT, coincident with ms 999→0 and sec=1. SAMPLE_STROBE fires 10 times, spaced 100,000 clocks.
- Bench-driven fast square wave (period 4 clocks), 3,600,000 ticks → hour=1, min=0, sec=0, ms=0. Preload near 255:59:59.999 and apply one tick → all fields 0, OVF=1.
- SNAP_REQ raised in the same cycle as the tick taking ms 41→42 → SNAP_MS=41, SNAP_ACK=1 next cycle. REQ held 50 cycles → SNAP_* unchanged. REQ low → SNAP_ACK 0 after 1 cycle.
- CLEAR asserted coincident with a tick at 00:00:05.500 → all counts 0, OVF 0, no PPS/SAMPLE pulse. Next tick → ms=1.
- RESET pulled low while SNAP_ACK=1 → SNAP_ACK and all counters 0 without a clock edge. After release, a new REQ completes the handshake normally.
